// File: rtl/ysyx_22041207_pkg.sv
// Shared definitions for the iterative RV64 divider: widths, FSM encoding,
// word-op extension helper and the RISC-V divide-by-zero quotient.
package ysyx_22041207_pkg;

    localparam int XLEN        = 64;
    localparam int CNT_W       = 7;
    localparam int WORD_W      = 32;
    localparam int WORD_SEXT_W = XLEN - WORD_W;

    localparam logic [XLEN-1:0] DZ_QUOTIENT = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Widen a 32-bit W-op value, sign- or zero-extending.
    function automatic logic [XLEN-1:0] word_ext(input logic [WORD_W-1:0] v,
                                                 input logic sext);
        return {{WORD_SEXT_W{sext & v[WORD_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22041207_div_fix.sv
// Conditional two's-complement negate followed by optional W-op sign extension.
// Serves both for operand magnitudes and for the final result fix-up.
module ysyx_22041207_div_fix
    import ysyx_22041207_pkg::*;
(
    input  logic [XLEN-1:0] val,
    input  logic            neg,
    input  logic            word,
    output logic [XLEN-1:0] res
);

    logic [XLEN-1:0] mag;

    always_comb begin
        mag = neg ? (~val + {{(XLEN-1){1'b0}}, 1'b1}) : val;
        res = word ? word_ext(mag[WORD_W-1:0], 1'b1) : mag;
    end

endmodule

// File: rtl/ysyx_22041207_div.sv
// Radix-2 restoring divider for RV64 DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per cycle; the last result stays on quotient/remainder.
module ysyx_22041207_div
    import ysyx_22041207_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    input  logic            flush,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            div_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    // Handshake: a request is taken when div_valid is high and either the unit
    // is idle (div_ready) or flush aborts the current op in the same cycle.
    // A request seen while busy without flush is dropped; the requester holds
    // div_valid until div_ready. out_valid pulses for one cycle per completed op.

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] quotient_q, quotient_d;
    logic [XLEN-1:0] remainder_q, remainder_d;

    logic [XLEN-1:0] dividend_ext, divisor_ext;
    logic [XLEN-1:0] dividend_mag, divisor_mag;
    logic            dividend_neg, divisor_neg, divisor_zero;
    logic            accept;

    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] rem_diff, step_rem, step_quo;
    logic            step_ge;
    logic [XLEN-1:0] fix_quo, fix_rem;

    always_comb begin
        dividend_ext = div_word ? word_ext(dividend[WORD_W-1:0], div_signed) : dividend;
        divisor_ext  = div_word ? word_ext(divisor[WORD_W-1:0], div_signed) : divisor;
        dividend_neg = div_signed & dividend_ext[XLEN-1];
        divisor_neg  = div_signed & divisor_ext[XLEN-1];
        divisor_zero = (divisor_ext == '0);
    end

    ysyx_22041207_div_fix u_mag_dividend (
        .val  (dividend_ext),
        .neg  (dividend_neg),
        .word (1'b0),
        .res  (dividend_mag)
    );

    ysyx_22041207_div_fix u_mag_divisor (
        .val  (divisor_ext),
        .neg  (divisor_neg),
        .word (1'b0),
        .res  (divisor_mag)
    );

    ysyx_22041207_div_fix u_fix_quo (
        .val  (quo_q),
        .neg  (q_neg_q),
        .word (word_q),
        .res  (fix_quo)
    );

    ysyx_22041207_div_fix u_fix_rem (
        .val  (rem_q),
        .neg  (r_neg_q),
        .word (word_q),
        .res  (fix_rem)
    );

    // The true difference always fits XLEN bits once rem_shift >= divisor.
    always_comb begin
        rem_shift = {rem_q, quo_q[XLEN-1]};
        step_ge   = (rem_shift >= {1'b0, dsr_q});
        rem_diff  = rem_shift[XLEN-1:0] - dsr_q;
        step_rem  = step_ge ? rem_diff : rem_shift[XLEN-1:0];
        step_quo  = {quo_q[XLEN-2:0], step_ge};
    end

    assign div_ready = (state_q == ST_IDLE);
    assign accept    = div_valid & (div_ready | flush);
    assign out_valid = (state_q == ST_DONE) & ~flush;
    assign quotient  = (state_q == ST_DONE) ? fix_quo : quotient_q;
    assign remainder = (state_q == ST_DONE) ? fix_rem : remainder_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        word_d      = word_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            ST_BUSY: begin
                rem_d   = step_rem;
                quo_d   = step_quo;
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                quotient_d  = fix_quo;
                remainder_d = fix_rem;
            end
            default: ;
        endcase

        if (flush && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end

        // Divide-by-zero goes straight to DONE with the RISC-V result preloaded
        // and no sign correction; word extension still applies in the fix-up.
        if (accept) begin
            count_d = '0;
            word_d  = div_word;
            dsr_d   = divisor_mag;
            if (divisor_zero) begin
                state_d = ST_DONE;
                quo_d   = DZ_QUOTIENT;
                rem_d   = dividend_ext;
                q_neg_d = 1'b0;
                r_neg_d = 1'b0;
            end else begin
                state_d = ST_BUSY;
                quo_d   = dividend_mag;
                rem_d   = '0;
                q_neg_d = dividend_neg ^ divisor_neg;
                r_neg_d = dividend_neg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            word_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            word_q      <= word_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_div.sv
// Directed and randomized bench for the RV64 divider; results are compared with
// a plain-arithmetic RISC-V division model.
module tb_ysyx_22041207_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid;
    logic        flush;
    logic        div_signed;
    logic        div_word;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_ready;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last_q   = '0;
    logic [63:0] last_r   = '0;

    always #5 clk = ~clk;

    ysyx_22041207_div dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .flush      (flush),
        .div_signed (div_signed),
        .div_word   (div_word),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_ready  (div_ready),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // RISC-V M-extension semantics, including divide-by-zero and overflow.
    function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                    input logic s, input logic w,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q = '1;
                r = sext32(a32);
            end else begin
                if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                    q32 = a32;
                    r32 = '0;
                end else if (s) begin
                    q32 = $signed(a32) / $signed(b32);
                    r32 = $signed(a32) % $signed(b32);
                end else begin
                    q32 = a32 / b32;
                    r32 = a32 % b32;
                end
                q = sext32(q32);
                r = sext32(r32);
            end
        end else if (b == 64'd0) begin
            q = '1;
            r = a;
        end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q = a;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!div_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!div_ready) check({tag, "_ready_timeout"}, 64'(div_ready), 64'd1);
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
        wait_ready("start");
        div_valid  = 1'b1;
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_word   = w;
        @(negedge clk);
        div_valid  = 1'b0;
        #1;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          input logic w, input logic with_flush, input string tag);
        logic [63:0] eq, er;
        int          k, exp_lat;
        logic        ready_bad;
        ref_div(a, b, s, w, eq, er);
        exp_lat = (w ? (b[31:0] == 32'd0) : (b == 64'd0)) ? 1 : 65;
        if (!with_flush) wait_ready(tag);
        div_valid  = 1'b1;
        flush      = with_flush;
        dividend   = a;
        divisor    = b;
        div_signed = s;
        div_word   = w;
        k          = 0;
        ready_bad  = 1'b0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                div_valid = 1'b0;
                flush     = 1'b0;
            end
            #1;
            if (div_ready) ready_bad = 1'b1;
        end while (!out_valid && k < 200);
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        last_q = eq;
        last_r = er;
        @(negedge clk);
        #1;
        check({tag, "_pulse_once"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_after"}, 64'(div_ready), 64'd1);
        check({tag, "_q_held"}, quotient, eq);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 4))
            0: v = 64'($urandom_range(1, 15));
            1: v = -64'($urandom_range(1, 15));
            2: v = 64'd0;
            3: v = {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63);
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        logic ov_seen;
        rst        = 1'b1;
        div_valid  = 1'b0;
        flush      = 1'b0;
        div_signed = 1'b0;
        div_word   = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 64'(div_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_quotient", quotient, 64'd0);
        check("reset_remainder", remainder, 64'd0);

        run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, "divu_100_7");
        check("divu_100_7_q_value", last_q, 64'd14);
        run_op(-64'd7, 64'd2, 1'b1, 1'b0, 1'b0, "div_m7_2");
        run_op(64'd7, -64'd2, 1'b1, 1'b0, 1'b0, "div_7_m2");
        run_op(64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, "div_by_zero");
        run_op(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, "div_overflow");
        run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, "divw_overflow");
        run_op(64'h1234_5678_0000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b0, "divuw_zero");

        // Abort mid-operation: no result, old outputs retained.
        start_op(64'd999, 64'd13, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_ready", 64'(div_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_q_untouched", quotient, last_q);
        check("flush_r_untouched", remainder, last_r);
        ov_seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            #1;
            if (out_valid) ov_seen = 1'b1;
        end
        check("flush_no_out_valid", 64'(ov_seen), 64'd0);

        // Flush together with a new request: only the new op completes.
        start_op(64'd5555, 64'd11, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        run_op(-64'd1000, 64'd33, 1'b1, 1'b0, 1'b1, "flush_and_valid");

        // Reset in the middle of an operation.
        start_op(64'd77777, 64'd9, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midop_rst_ready", 64'(div_ready), 64'd1);
        check("midop_rst_out_valid", 64'(out_valid), 64'd0);
        check("midop_rst_quotient", quotient, 64'd0);
        check("midop_rst_remainder", remainder, 64'd0);

        for (int i = 0; i < 24; i++) begin
            run_op(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, $sformatf("rand_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
